mips_multicycle: RTL

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: one shared memory port, internal 32x32 register file,
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) sequencing with an absorbing HALT on illegal opcodes.

module mips_multicycle #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       pc,
   output logic [2:0]        state,
   output logic              retire,
   output logic              halted,
   input  logic [4:0]        dbg_sel,
   output logic [31:0]       dbg_data
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
   logic [31:0] r_rf [32];

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_dest;
   logic [31:0] w_sext, w_alu, w_wb_data;
   logic        w_legal, w_req, w_we, w_is_sw;

   assign w_op      = r_ir[31:26];
   assign w_rs      = r_ir[25:21];
   assign w_rt      = r_ir[20:16];
   assign w_rd      = r_ir[15:11];
   assign w_funct   = r_ir[5:0];
   assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_is_sw   = (w_op == OP_SW);
   assign w_dest    = (w_op == OP_RTYPE) ? w_rd : w_rt;
   assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu_out;

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         OP_RTYPE: w_legal = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                             (w_funct == FN_OR)  || (w_funct == FN_SLT);
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: w_legal = 1'b1;
         default: w_legal = 1'b0;
      endcase
   end

   // addi, lw and sw all share the A + sext(imm16) path
   always_comb begin
      w_alu = r_a + w_sext;
      if (w_op == OP_RTYPE) begin
         case (w_funct)
            FN_SUB:  w_alu = r_a - r_b;
            FN_AND:  w_alu = r_a & r_b;
            FN_OR:   w_alu = r_a | r_b;
            FN_SLT:  w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
            default: w_alu = r_a + r_b;
         endcase
      end
   end

   always_comb begin
      w_next   = r_state;
      w_req    = 1'b0;
      w_we     = 1'b0;
      mem_addr = r_pc[ADDR_W-1:0];
      retire   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req = 1'b1;
            if (mem_ack) w_next = S_DECODE;
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            if ((w_op == OP_BEQ) || (w_op == OP_J)) begin
               retire = 1'b1;
               w_next = S_FETCH;
            end else if ((w_op == OP_LW) || w_is_sw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            w_req    = 1'b1;
            w_we     = w_is_sw;
            mem_addr = r_alu_out[ADDR_W-1:0];
            if (mem_ack) begin
               retire = w_is_sw;
               w_next = w_is_sw ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            retire = 1'b1;
            w_next = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

   // request is killed combinationally so an assert of rst mid-transaction drops it at once
   assign mem_req   = w_req & ~rst;
   assign mem_we    = w_we & ~rst;
   assign mem_wdata = r_b;
   assign pc        = r_pc;
   assign state     = r_state;
   assign halted    = (r_state == S_HALT);
   assign dbg_data  = (dbg_sel == 5'd0) ? 32'h0 : r_rf[dbg_sel];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_mdr     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu_out <= '0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ack) begin
                  r_ir <= mem_rdata;
                  r_pc <= r_pc + 32'd4;
               end
            end
            S_DECODE: begin
               r_a       <= r_rf[w_rs];
               r_b       <= r_rf[w_rt];
               r_alu_out <= r_pc + {w_sext[29:0], 2'b00};
            end
            S_EXEC: begin
               if (w_op == OP_BEQ) begin
                  if (r_a == r_b) r_pc <= r_alu_out;
               end else if (w_op == OP_J) begin
                  r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
               end else begin
                  r_alu_out <= w_alu;
               end
            end
            S_MEM: begin
               if (mem_ack && !w_is_sw) r_mdr <= mem_rdata;
            end
            S_WB: begin
               if (w_dest != 5'd0) r_rf[w_dest] <= w_wb_data;
            end
            default: ;
         endcase
      end
   end

endmodule
